wb_digpot_mon: RTL and testbench
================================

Name: wb_digpot_mon

Overview:
- Wishbone-readable monitor on the pins between the wiper controller and the X9C-style digital pot, i.e. the pot side of the INC/UDn/CSn interface.
- Synchronises and deglitches INC/UDn/CSn, decodes step and store events, and tracks wiper position, stored (nonvolatile) position and event counters.
- Lets firmware verify the pulses actually issued; also serves as a behavioural pot stand-in for system simulation.

Parameters:
- STEPS, 100, number of wiper taps; position range 0..STEPS-1.
- POS_W, 7, position width; must satisfy STEPS <= 2**POS_W.
- FILT, 4, consecutive equal samples (clk cycles) before a synchronised pin level is accepted; range 1..15.
- INIT_POS, 0, position and stored position after reset.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- wb_stb_i  in  1  Wishbone strobe
- wb_cyc_i  in  1  Wishbone cycle
- wb_ack_o  out  1  Wishbone acknowledge
- wb_we_i  in  1  write enable
- wb_adr_i  in  32  address; only [3:2] decoded
- wb_sel_i  in  4  byte selects; ignored, full-word access only
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- inc_i  in  1  pot INC pin, asynchronous to clk
- udn_i  in  1  pot U/Dn pin; 1 = up, 0 = down
- csn_i  in  1  pot chip select, active low
- irq_o  out  1  event interrupt; see Optional Feature

Behaviour:
- Pin path: 2-flop synchroniser per pin, then a per-pin filter that updates its output only after FILT consecutive equal samples. Filter reset values: inc=1, csn=1, udn=0. Pin-to-event latency is 2+FILT cycles.
- FSM on filtered signals. States: IDLE (csn=1), SEL_HI (csn=0, inc=1), SEL_LO (csn=0, inc=0).
  - IDLE -> SEL_HI when csn falls with inc=1.
  - IDLE -> SEL_LO when csn falls with inc=0; no step is counted for that entry.
  - SEL_HI -> SEL_LO on inc fall: STEP event; direction = filtered udn sampled in the same cycle.
  - SEL_LO -> SEL_HI on inc rise: no event.
  - SEL_HI -> IDLE on csn rise: STORE event.
  - SEL_LO -> IDLE on csn rise: plain deselect, no store.
- STEP event:
  - Up: pos+1, saturating at STEPS-1. A step attempted at STEPS-1 sets sticky SAT_HI.
  - Down: pos-1, saturating at 0. A step attempted at 0 sets sticky SAT_LO.
  - step_cnt (8 bit) increments for every step, saturated or not, and wraps 255->0.
- STORE event: stored_pos <= pos; store_cnt (8 bit, wrapping) increments; sticky STORED sets.
- CTRL.EN=0: FSM held in IDLE, no events. Synchronisers and filters keep running.
- Register map, by wb_adr_i[3:2]:
  - 0 POS, RO: [POS_W-1:0] pos, [15:8] stored_pos.
  - 1 STAT: [0] busy (csn low, RO), [1] SAT_HI, [2] SAT_LO, [3] STORED, [15:8] step_cnt, [23:16] store_cnt. Bits [3:1] are W1C. Writing bit31=1 clears both counters.
  - 2 PRESET, WO (reads 0): pos <= stored_pos <= min(wb_dat_i[POS_W-1:0], STEPS-1).
  - 3 CTRL, RW: [0] EN (reset 1), [1] IRQ_EN (reset 0).
- Unused read bits return 0.
- Wishbone handshake:
  - ack is registered; it sets one cycle after stb&cyc and clears the following cycle.
  - wb_ack_o = stb & cyc & ack.
  - Writes take effect on the ack cycle; wb_dat_o is registered and valid with ack.
- Simultaneous events in one cycle:
  - PRESET write vs STEP: preset value wins; step_cnt and sticky flags still update.
  - W1C vs new sticky event on the same bit: flag stays set.
  - Counter clear vs event: counter ends at 0.
- Reset (asynchronous, may arrive mid-transaction or mid-pulse): pos = stored_pos = INIT_POS, counters 0, flags 0, FSM IDLE, ack 0, wb_dat_o 0, irq_o 0, EN 1, IRQ_EN 0.

Optional Feature:
- Macro DIGPOT_MON_IRQ_EN.
- Defined: irq_o = IRQ_EN & (SAT_HI | SAT_LO | STORED), registered, level-held until the flags are cleared.
- Undefined: irq_o tied 0; CTRL[1] reads 0 and ignores writes.

Decomposition:
- Shared package/include: register address constants (POS=0, STAT=1, PRESET=2, CTRL=3), STAT/CTRL bit indices, FSM state encodings.
- One sub-module: digpot_pin_filter (2-flop sync plus FILT counter, one instance per pin).

Test Plan:
- Reset, read POS -> 0x00000000; read CTRL -> 0x1; irq_o=0.
- CSn low, 5 INC falls with UDn=1, CSn high with INC high -> POS=0x0505 (pos 5, stored 5); STAT step_cnt=5, store_cnt=1, STORED=1.
- PRESET 98, 4 up-steps -> pos=99, SAT_HI=1, step_cnt=4; write STAT 0x2 -> SAT_HI=0.
- 2-cycle INC glitch with FILT=4 -> no step, step_cnt unchanged.
- CSn rises while INC low after 3 down-steps from pos 10 -> pos=7, stored_pos unchanged, store_cnt unchanged.
- With DIGPOT_MON_IRQ_EN, IRQ_EN=1, down-step at pos 0 -> SAT_LO=1, irq_o=1 two cycles later; W1C bit2 -> irq_o=0.

Source files
------------

// File: rtl/wb_digpot_mon_pkg.sv
// Shared constants for the digital-pot pin monitor: register addresses, STAT/CTRL
// bit positions and the pot-side FSM state encoding.
package wb_digpot_mon_pkg;

   localparam logic [1:0] ADR_POS    = 2'd0;
   localparam logic [1:0] ADR_STAT   = 2'd1;
   localparam logic [1:0] ADR_PRESET = 2'd2;
   localparam logic [1:0] ADR_CTRL   = 2'd3;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_SAT_HI  = 1;
   localparam int STAT_SAT_LO  = 2;
   localparam int STAT_STORED  = 3;
   localparam int STAT_CLR_CNT = 31;

   localparam int CTRL_EN     = 0;
   localparam int CTRL_IRQ_EN = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEL_HI = 2'd1,
      ST_SEL_LO = 2'd2
   } pot_state_e;

endpackage

// File: rtl/wb_digpot_mon_pin_filter.sv
// Two-flop synchroniser plus deglitch filter for one pot pin; the output only
// follows the synchronised level after FILT consecutive differing samples.
module digpot_pin_filter #(
   parameter int   FILT    = 4,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic pin_i,
   output logic pin_o
);

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       filt_q, filt_d;
   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = pin_i;
      sync2_d = sync1_q;
      filt_d  = filt_q;
      cnt_d   = '0;
      // Any sample matching the accepted level restarts the run.
      if (sync2_q != filt_q) begin
         if (cnt_q == 4'(FILT - 1)) filt_d = sync2_q;
         else                       cnt_d  = cnt_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= RST_VAL;
         sync2_q <= RST_VAL;
         filt_q  <= RST_VAL;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pin_o = filt_q;

endmodule

// File: rtl/wb_digpot_mon.sv
// Wishbone-readable monitor of the X9C-style pot pins (INC/UDn/CSn): tracks wiper
// and stored position plus event counters. Macro DIGPOT_MON_IRQ_EN adds irq_o.
module wb_digpot_mon #(
   parameter int STEPS    = 100,
   parameter int POS_W    = 7,
   parameter int FILT     = 4,
   parameter int INIT_POS = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   input  logic        wb_we_i,
   input  logic [31:0] wb_adr_i,
   input  logic [3:0]  wb_sel_i,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        inc_i,
   input  logic        udn_i,
   input  logic        csn_i,
   output logic        irq_o
);
   import wb_digpot_mon_pkg::*;

   localparam logic [POS_W-1:0] POS_MAX  = POS_W'(STEPS - 1);
   localparam logic [POS_W-1:0] POS_INIT = POS_W'(INIT_POS);

   logic inc_f, udn_f, csn_f;

   digpot_pin_filter #(.FILT(FILT), .RST_VAL(1'b1)) u_inc_filt (
      .clk(clk), .reset(reset), .pin_i(inc_i), .pin_o(inc_f));
   digpot_pin_filter #(.FILT(FILT), .RST_VAL(1'b0)) u_udn_filt (
      .clk(clk), .reset(reset), .pin_i(udn_i), .pin_o(udn_f));
   digpot_pin_filter #(.FILT(FILT), .RST_VAL(1'b1)) u_csn_filt (
      .clk(clk), .reset(reset), .pin_i(csn_i), .pin_o(csn_f));

   pot_state_e       state_q, state_d;
   logic             step_ev, store_ev;
   logic             en_q, en_d;
   logic             irq_en;
   logic [POS_W-1:0] pos_q, pos_d, stored_q, stored_d, preset_val;
   logic             sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d, stored_f_q, stored_f_d;
   logic [7:0]       step_cnt_q, step_cnt_d, store_cnt_q, store_cnt_d;
   logic             ack_q, ack_d;
   logic [31:0]      dat_q, dat_d, rd_data;
   logic [1:0]       adr;
   logic             bus_req, wr_en, wr_stat, wr_preset, wr_ctrl, clr_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (!en_q) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   if (!csn_f) state_d = inc_f ? ST_SEL_HI : ST_SEL_LO;
            ST_SEL_HI: if (csn_f) state_d = ST_IDLE; else if (!inc_f) state_d = ST_SEL_LO;
            ST_SEL_LO: if (csn_f) state_d = ST_IDLE; else if (inc_f)  state_d = ST_SEL_HI;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      step_ev  = 1'b0;
      store_ev = 1'b0;
      if (en_q && state_q == ST_SEL_HI) begin
         if (csn_f)       store_ev = 1'b1;
         else if (!inc_f) step_ev  = 1'b1;
      end
   end

   assign adr       = wb_adr_i[3:2];
   assign bus_req   = wb_stb_i & wb_cyc_i;
   assign wr_en     = bus_req & ack_q & wb_we_i;
   assign wr_stat   = wr_en && (adr == ADR_STAT);
   assign wr_preset = wr_en && (adr == ADR_PRESET);
   assign wr_ctrl   = wr_en && (adr == ADR_CTRL);
   assign clr_cnt   = wr_stat & wb_dat_i[STAT_CLR_CNT];
   assign preset_val = (wb_dat_i[POS_W-1:0] > POS_MAX) ? POS_MAX : wb_dat_i[POS_W-1:0];

   always_comb begin
      pos_d      = pos_q;
      stored_d   = stored_q;
      sat_hi_d   = sat_hi_q;
      sat_lo_d   = sat_lo_q;
      stored_f_d = stored_f_q;
      en_d       = en_q;
      step_cnt_d  = clr_cnt ? 8'd0 : step_cnt_q  + {7'd0, step_ev};
      store_cnt_d = clr_cnt ? 8'd0 : store_cnt_q + {7'd0, store_ev};
      // Clears are applied first so a same-cycle event leaves its flag set.
      if (wr_stat) begin
         if (wb_dat_i[STAT_SAT_HI]) sat_hi_d   = 1'b0;
         if (wb_dat_i[STAT_SAT_LO]) sat_lo_d   = 1'b0;
         if (wb_dat_i[STAT_STORED]) stored_f_d = 1'b0;
      end
      if (step_ev) begin
         if (udn_f) begin
            if (pos_q == POS_MAX) sat_hi_d = 1'b1;
            else                  pos_d    = pos_q + 1'b1;
         end else begin
            if (pos_q == '0) sat_lo_d = 1'b1;
            else             pos_d    = pos_q - 1'b1;
         end
      end
      if (store_ev) begin
         stored_d   = pos_q;
         stored_f_d = 1'b1;
      end
      if (wr_preset) begin
         pos_d    = preset_val;
         stored_d = preset_val;
      end
      if (wr_ctrl) en_d = wb_dat_i[CTRL_EN];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_q       <= POS_INIT;
         stored_q    <= POS_INIT;
         sat_hi_q    <= 1'b0;
         sat_lo_q    <= 1'b0;
         stored_f_q  <= 1'b0;
         step_cnt_q  <= '0;
         store_cnt_q <= '0;
         en_q        <= 1'b1;
      end else begin
         pos_q       <= pos_d;
         stored_q    <= stored_d;
         sat_hi_q    <= sat_hi_d;
         sat_lo_q    <= sat_lo_d;
         stored_f_q  <= stored_f_d;
         step_cnt_q  <= step_cnt_d;
         store_cnt_q <= store_cnt_d;
         en_q        <= en_d;
      end
   end

`ifdef DIGPOT_MON_IRQ_EN
   logic irq_en_q, irq_en_d, irq_q, irq_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_ctrl) irq_en_d = wb_dat_i[CTRL_IRQ_EN];
      irq_d = irq_en_q & (sat_hi_q | sat_lo_q | stored_f_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_en = irq_en_q;
   assign irq_o  = irq_q;
`else
   assign irq_en = 1'b0;
   assign irq_o  = 1'b0;
`endif

   always_comb begin
      rd_data = '0;
      case (adr)
         ADR_POS: begin
            rd_data[POS_W-1:0]  = pos_q;
            rd_data[8 +: POS_W] = stored_q;
         end
         ADR_STAT: begin
            rd_data[STAT_BUSY]   = ~csn_f;
            rd_data[STAT_SAT_HI] = sat_hi_q;
            rd_data[STAT_SAT_LO] = sat_lo_q;
            rd_data[STAT_STORED] = stored_f_q;
            rd_data[15:8]        = step_cnt_q;
            rd_data[23:16]       = store_cnt_q;
         end
         ADR_CTRL: begin
            rd_data[CTRL_EN]     = en_q;
            rd_data[CTRL_IRQ_EN] = irq_en;
         end
         default: rd_data = '0;
      endcase
   end

   // Read data is captured alongside ack so it is valid in the ack cycle.
   always_comb begin
      ack_d = bus_req & ~ack_q;
      dat_d = dat_q;
      if (bus_req && !ack_q) dat_d = rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
      end
   end

   assign wb_ack_o = bus_req & ack_q;
   assign wb_dat_o = dat_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i};

endmodule

// File: tb/tb_wb_digpot_mon.sv
// Scoreboard bench for wb_digpot_mon: a behavioural pot model predicts register reads,
// expected values are queued at issue time and compared when the DUT acks.
module tb_wb_digpot_mon;

   localparam int FILT  = 4;
   localparam int STEPS = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
   logic        wb_ack_o;
   logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
   logic [3:0]  wb_sel_i = 4'hF;
   logic        inc_i = 1'b1, udn_i = 1'b0, csn_i = 1'b1;
   logic        irq_o;

   wb_digpot_mon #(.STEPS(STEPS), .POS_W(7), .FILT(FILT), .INIT_POS(0)) dut (
      .clk(clk), .reset(reset),
      .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o), .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .inc_i(inc_i), .udn_i(udn_i), .csn_i(csn_i), .irq_o(irq_o));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   string       tag_q[$];

   // Behavioural pot model
   int   m_pos, m_stored, m_step_cnt, m_store_cnt, m_st;
   logic m_sat_hi, m_sat_lo, m_stored_f, m_en, m_irq_en;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (wb_ack_o && !wb_we_i) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_ack", {31'd0, wb_ack_o}, 32'd0);
         end else begin
            automatic logic [31:0] e = exp_q.pop_front();
            automatic string t = tag_q.pop_front();
            check_eq(t, wb_dat_o, e);
         end
      end
   end

   task automatic model_reset();
      m_pos = 0; m_stored = 0; m_step_cnt = 0; m_store_cnt = 0; m_st = 0;
      m_sat_hi = 0; m_sat_lo = 0; m_stored_f = 0; m_en = 1; m_irq_en = 0;
   endtask

   function automatic logic [31:0] exp_pos();
      return (32'(m_stored) << 8) | 32'(m_pos);
   endfunction

   function automatic logic [31:0] exp_stat();
      return (32'(m_store_cnt) << 16) | (32'(m_step_cnt) << 8) |
             {28'd0, m_stored_f, m_sat_lo, m_sat_hi, ~csn_i};
   endfunction

   function automatic logic [31:0] exp_ctrl();
      return {30'd0, m_irq_en, m_en};
   endfunction

   function automatic logic exp_irq();
      return m_irq_en & (m_sat_hi | m_sat_lo | m_stored_f);
   endfunction

   task automatic settle();
      repeat (FILT + 6) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic we, input logic [1:0] a, input logic [31:0] d);
      int n = 0;
      @(posedge clk); #1;
      wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
      wb_adr_i = {28'd0, a, 2'b00}; wb_dat_i = d;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!wb_ack_o && n < 10);
      if (!wb_ack_o) check_eq("ack_timeout", {31'd0, wb_ack_o}, 32'd1);
      @(posedge clk); #1;
      wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      xfer(1'b0, a, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      xfer(1'b1, a, d);
      case (a)
         2'd1: begin
            if (d[1]) m_sat_hi = 0;
            if (d[2]) m_sat_lo = 0;
            if (d[3]) m_stored_f = 0;
            if (d[31]) begin m_step_cnt = 0; m_store_cnt = 0; end
         end
         2'd2: begin
            m_pos = (int'(d[6:0]) > STEPS - 1) ? STEPS - 1 : int'(d[6:0]);
            m_stored = m_pos;
         end
         2'd3: begin
            m_en = d[0];
`ifdef DIGPOT_MON_IRQ_EN
            m_irq_en = d[1];
`else
            m_irq_en = 0;
`endif
         end
         default: ;
      endcase
   endtask

   task automatic model_step();
      m_step_cnt = (m_step_cnt + 1) % 256;
      if (udn_i) begin
         if (m_pos == STEPS - 1) m_sat_hi = 1; else m_pos++;
      end else begin
         if (m_pos == 0) m_sat_lo = 1; else m_pos--;
      end
   endtask

   task automatic set_inc(input logic v);
      if (m_en && !csn_i) begin
         if (!v && inc_i && m_st == 1) begin model_step(); m_st = 2; end
         else if (v && !inc_i && m_st == 2) m_st = 1;
      end
      inc_i = v;
      settle();
   endtask

   task automatic set_csn(input logic v);
      if (m_en) begin
         if (!v && csn_i) m_st = inc_i ? 1 : 2;
         else if (v && !csn_i) begin
            if (m_st == 1) begin
               m_stored = m_pos; m_stored_f = 1;
               m_store_cnt = (m_store_cnt + 1) % 256;
            end
            m_st = 0;
         end
      end
      csn_i = v;
      settle();
   endtask

   task automatic pulse();
      set_inc(1'b0);
      set_inc(1'b1);
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      settle();

      // Reset state
      check_eq("irq_rst", {31'd0, irq_o}, {31'd0, exp_irq()});
      rd(2'd0, exp_pos(),  "pos_rst");
      rd(2'd3, exp_ctrl(), "ctrl_rst");
      rd(2'd1, exp_stat(), "stat_rst");

      // Five up-steps then store
      udn_i = 1'b1; settle();
      set_csn(1'b0);
      repeat (5) pulse();
      set_csn(1'b1);
      rd(2'd0, exp_pos(),  "pos_5up");
      rd(2'd1, exp_stat(), "stat_5up");

      // Saturation at the top, counter clear, W1C
      wr(2'd1, 32'h8000_0000);
      wr(2'd2, 32'd98);
      rd(2'd0, exp_pos(), "pos_preset98");
      set_csn(1'b0);
      repeat (4) pulse();
      rd(2'd1, exp_stat(), "stat_sat_hi");
      set_csn(1'b1);
      rd(2'd0, exp_pos(), "pos_top");
      wr(2'd1, 32'h0000_0002);
      rd(2'd1, exp_stat(), "stat_w1c_hi");

      // Short INC glitch is filtered out
      set_csn(1'b0);
      inc_i = 1'b0; repeat (2) @(posedge clk); #1; inc_i = 1'b1;
      settle();
      rd(2'd1, exp_stat(), "stat_glitch");
      set_csn(1'b1);

      // Deselect with INC low: no store
      wr(2'd2, 32'd10);
      udn_i = 1'b0; settle();
      set_csn(1'b0);
      repeat (2) pulse();
      set_inc(1'b0);
      set_csn(1'b1);
      set_inc(1'b1);
      rd(2'd0, exp_pos(),  "pos_nostore");
      rd(2'd1, exp_stat(), "stat_nostore");

      // PRESET clamps to the top tap and reads back as zero
      wr(2'd2, 32'h0000_00FF);
      rd(2'd0, exp_pos(), "pos_clamp");
      rd(2'd2, 32'd0,     "preset_rd");

      // Bottom saturation and interrupt
      wr(2'd1, 32'h0000_000E);
      wr(2'd2, 32'd0);
      wr(2'd3, 32'd3);
      rd(2'd3, exp_ctrl(), "ctrl_irq_en");
      set_csn(1'b0);
      set_inc(1'b0);
      rd(2'd1, exp_stat(), "stat_sat_lo");
      check_eq("irq_sat_lo", {31'd0, irq_o}, {31'd0, exp_irq()});
      wr(2'd1, 32'h0000_0004);
      repeat (2) @(posedge clk); #1;
      check_eq("irq_cleared", {31'd0, irq_o}, {31'd0, exp_irq()});
      set_csn(1'b1);
      set_inc(1'b1);
      rd(2'd0, exp_pos(), "pos_bottom");

      // EN=0 suppresses events
      wr(2'd3, 32'd0);
      udn_i = 1'b1; settle();
      set_csn(1'b0);
      repeat (2) pulse();
      set_csn(1'b1);
      rd(2'd1, exp_stat(), "stat_disabled");
      rd(2'd0, exp_pos(),  "pos_disabled");
      wr(2'd3, 32'd1);
      rd(2'd3, exp_ctrl(), "ctrl_reen");

      // Asynchronous reset in the middle of a pulse
      set_csn(1'b0);
      inc_i = 1'b0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      model_reset();
      #1 check_eq("irq_async_rst", {31'd0, irq_o}, 32'd0);
      check_eq("ack_async_rst", {31'd0, wb_ack_o}, 32'd0);
      inc_i = 1'b1; csn_i = 1'b1; udn_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      settle();
      rd(2'd0, exp_pos(),  "pos_after_rst");
      rd(2'd1, exp_stat(), "stat_after_rst");
      rd(2'd3, exp_ctrl(), "ctrl_after_rst");

      repeat (4) @(posedge clk); #1;
      check_eq("sb_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
